bcd_serial_subtractor: RTL and testbench
========================================

Name: bcd_serial_subtractor

Overview:
Multi-digit packed-BCD subtractor that computes A - B one decimal digit per clock, least-significant digit first. The operands are latched on a start handshake. Each digit passes through a combinational single-digit BCD subtract stage, and a registered borrow chains from one digit to the next. The block sits above the single-digit stage in the arithmetic datapath and delivers a full-width ten's-complement difference with a final borrow flag.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal range 1..16).

Ports:
clk_i  input  1  single clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  request a subtraction; sampled only in IDLE or DONE
a_i  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0]
b_i  input  4*DIGITS  subtrahend, packed BCD, same packing
busy_o  output  1  high while in RUN
done_o  output  1  one-cycle pulse when a result is published
diff_o  output  4*DIGITS  published difference, packed BCD
borrow_o  output  1  final borrow; 1 means A < B and diff_o is the ten's complement
invalid_o  output  1  last accepted operand pair contained a digit > 9

Behaviour:
- Reset: the block asynchronously enters IDLE. busy_o, done_o, borrow_o and invalid_o go to 0, diff_o goes to 0, and the internal operand, working and borrow registers are cleared. Reset during RUN abandons the operation with no done_o pulse.
- States:
  - IDLE: waits for start_i.
  - RUN: processes one digit per edge.
  - DONE: publishes the result; lasts exactly one cycle.
- Accept: on an edge with state IDLE or DONE and start_i=1:
  - latch a_i and b_i;
  - clear the digit index and the running borrow;
  - evaluate validity, i.e. whether any nibble of a_i or b_i is > 9.
- Invalid path: if any nibble is invalid, the next state is DONE immediately. At that edge diff_o=0, borrow_o=0 and invalid_o=1 are published, and done_o pulses one cycle later.
- Valid path: the next state is RUN and invalid_o stays at its old value until publication.
- RUN, each edge, for digit i (0..DIGITS-1):
  - t = a[i] - b[i] - borrow_in.
  - If t >= 0: digit = t and borrow_out = 0.
  - Otherwise: digit = t + 10 and borrow_out = 1.
  - Write the digit into working nibble i, register borrow_out, and increment i.
- Completion: at the edge that processes digit DIGITS-1, go to DONE and copy the working register into diff_o. Set borrow_o to that edge's borrow_out and invalid_o to 0.
- Latency: if start_i is sampled at edge k, done_o is high for exactly the cycle after edge k+DIGITS. On the invalid path, done_o is high for the cycle after edge k+1.
- busy_o is high for edges k..k+DIGITS-1 (RUN only).
- diff_o, borrow_o and invalid_o change only at publication and hold their values until the next publication or reset.
- start_i is ignored in RUN; there is no queuing.
- start_i asserted in DONE is accepted, giving back-to-back operations with no IDLE gap. done_o still pulses for the DONE cycle.
- DONE with no start_i returns to IDLE.
- Digit arithmetic uses a 5-bit signed intermediate; nibble results are always 0..9.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - BCD_MAX = 4'd9;
  - BCD_BASE = 5'd10;
  - nibble typedef bcd_digit_t.
- One sub-module, bcd_digit_sub: a combinational single-digit stage with inputs a, b, borrow_in and outputs digit, borrow_out, exactly per the RUN rule.
- The sequencer, digit index counter and publication registers live in bcd_serial_subtractor.

Test Plan:
1. DIGITS=4, A=4521, B=1234, start at edge k -> done_o pulses in the cycle after edge k+4; diff_o=3287, borrow_o=0, invalid_o=0; busy_o high for 4 cycles.
2. A=0123, B=0456 -> diff_o=9667, borrow_o=1 (ten's complement of -333).
3. A=1000, B=0001 -> borrow ripples through all digits; diff_o=0999, borrow_o=0. A=0000, B=0000 -> diff_o=0000, borrow_o=0.
4. A=12A4 (nibble 0xA), B=0001 -> done_o pulses in the cycle after edge k+1; diff_o=0, borrow_o=0, invalid_o=1. The previous diff_o is held until that edge.
5. start_i re-asserted during RUN -> ignored and the result is unchanged. start_i held high through DONE -> second operation (A=9999, B=9999 -> 0000, borrow_o=0) accepted with no IDLE cycle.
6. rst_i asserted mid-RUN (after 2 digits) -> all outputs 0 asynchronously, no done_o. A fresh start then produces the correct result (A=5000, B=0001 -> 4999).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD arithmetic datapath.
//   state_t     : sequencer states of the serial subtractor
//   BCD_MAX     : largest legal BCD nibble value
//   BCD_BASE    : decimal radix, used for borrow correction
//   bcd_digit_t : one BCD nibble
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [4:0] BCD_BASE = 5'd10;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract stage: digit = a - b - borrow_in,
// corrected by +10 when the raw result is negative.
//   a, b       : input BCD digits (expected 0..9)
//   borrow_in  : borrow from the next-lower digit
//   digit      : result digit, 0..9
//   borrow_out : 1 when the raw difference went negative
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       borrow_in,
    output bcd_digit_t digit,
    output logic       borrow_out
);

    logic signed [4:0] t;
    logic        [4:0] t_fix;

    always_comb begin
        t          = $signed({1'b0, a} - {1'b0, b} - {4'b0000, borrow_in});
        borrow_out = (t < 0);
        // Adding the radix wraps modulo 32, so the low nibble is the
        // corrected digit for any t in -10..-1.
        t_fix      = 5'(t) + BCD_BASE;
        digit      = borrow_out ? t_fix[3:0] : t[3:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Multi-digit packed-BCD subtractor, one digit per clock, LSD first.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   start_i   : request; sampled in IDLE or DONE
//   a_i, b_i  : minuend / subtrahend, packed BCD, digit 0 in [3:0]
//   busy_o    : high while digits are being processed
//   done_o    : one-cycle pulse when a result has been published
//   diff_o    : published difference (ten's complement when borrow_o=1)
//   borrow_o  : final borrow, 1 means A < B
//   invalid_o : last accepted operands contained a nibble > 9
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   diff_o,
    output logic                  borrow_o,
    output logic                  invalid_o
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t           state_q, state_nxt;
    logic [W-1:0]     a_q, b_q, work_q, work_nxt;
    logic [IDX_W-1:0] idx_q;
    logic             borrow_q;
    logic             inv_pend_q;
    logic             done_q;
    logic [W-1:0]     diff_q;
    logic             borrow_out_q;
    logic             invalid_q;

    bcd_digit_t       cur_a, cur_b, sub_digit;
    logic             sub_bout;
    logic             any_bad;
    logic             accept;
    logic             last;

    always_comb begin
        cur_a   = '0;
        cur_b   = '0;
        any_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_a = a_q[4*i +: 4];
                cur_b = b_q[4*i +: 4];
            end
            if (a_i[4*i +: 4] > BCD_MAX || b_i[4*i +: 4] > BCD_MAX) begin
                any_bad = 1'b1;
            end
        end
    end

    bcd_digit_sub u_digit (
        .a          (cur_a),
        .b          (cur_b),
        .borrow_in  (borrow_q),
        .digit      (sub_digit),
        .borrow_out (sub_bout)
    );

    always_comb begin
        work_nxt = work_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                work_nxt[4*i +: 4] = sub_digit;
            end
        end
    end

    assign accept = start_i && (state_q == IDLE || state_q == DONE);
    assign last   = (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept) state_nxt = any_bad ? DONE : RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    state_nxt = accept ? (any_bad ? DONE : RUN) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            work_q       <= '0;
            idx_q        <= '0;
            borrow_q     <= 1'b0;
            inv_pend_q   <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            done_q  <= 1'b0;

            // An invalid operand pair publishes on acceptance but its done
            // pulse trails by one cycle, raised from the DONE state.
            if (state_q == DONE) begin
                inv_pend_q <= 1'b0;
                if (inv_pend_q) done_q <= 1'b1;
            end

            if (state_q == RUN) begin
                work_q   <= work_nxt;
                borrow_q <= sub_bout;
                idx_q    <= idx_q + IDX_W'(1);
                if (last) begin
                    diff_q       <= work_nxt;
                    borrow_out_q <= sub_bout;
                    invalid_q    <= 1'b0;
                    done_q       <= 1'b1;
                end
            end

            if (accept) begin
                a_q        <= a_i;
                b_q        <= b_i;
                work_q     <= '0;
                idx_q      <= '0;
                borrow_q   <= 1'b0;
                inv_pend_q <= any_bad;
                if (any_bad) begin
                    diff_q       <= '0;
                    borrow_out_q <= 1'b0;
                    invalid_q    <= 1'b1;
                end
            end
        end
    end

    assign busy_o    = (state_q == RUN);
    assign done_o    = done_q;
    assign diff_o    = diff_q;
    assign borrow_o  = borrow_out_q;
    assign invalid_o = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
module tb_bcd_serial_subtractor;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i, b_i;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         borrow, invalid;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy),
        .done_o    (done),
        .diff_o    (diff),
        .borrow_o  (borrow),
        .invalid_o (invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         inv;
        int           done_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint n);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Reference: decimal subtraction, wrapped to ten's complement on underflow.
    task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv, input int k);
        exp_t   e;
        longint d, p;
        if (has_bad(av) || has_bad(bv)) begin
            e.diff = '0; e.borrow = 1'b0; e.inv = 1'b1; e.done_cyc = k + 1;
        end else begin
            p = 1;
            for (int i = 0; i < DIGITS; i++) p = p * 10;
            d = bcd2int(av) - bcd2int(bv);
            e.borrow = (d < 0);
            if (d < 0) d = d + p;
            e.diff = int2bcd(d); e.inv = 1'b0; e.done_cyc = k + DIGITS;
        end
        q.push_back(e);
    endtask

    // Monitor / scoreboard
    logic [W-1:0] last_diff = '0;
    logic         last_borrow = 1'b0;
    logic         last_inv = 1'b0;
    int           busy_cnt = 0;
    exp_t         me;

    always @(negedge clk) begin
        if (rst) begin
            last_diff = '0; last_borrow = 1'b0; last_inv = 1'b0; busy_cnt = 0;
        end else begin
            if (done) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done_o=1 expected no pending result (cycle %0d)", cyc);
                end else begin
                    me = q.pop_front();
                    check("diff", 64'(diff), 64'(me.diff));
                    check("borrow", 64'(borrow), 64'(me.borrow));
                    check("invalid", 64'(invalid), 64'(me.inv));
                    check("done_cycle", 64'(cyc), 64'(me.done_cyc));
                    check("busy_cycles", 64'(busy_cnt), me.inv ? 64'd0 : 64'(DIGITS));
                    last_diff = me.diff; last_borrow = me.borrow; last_inv = me.inv;
                end
                busy_cnt = 0;
            end
            if (busy) begin
                busy_cnt++;
                check("hold_diff", 64'(diff), 64'(last_diff));
                check("hold_borrow", 64'(borrow), 64'(last_borrow));
                check("hold_invalid", 64'(invalid), 64'(last_inv));
            end
        end
    end

    // Stimulus
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        a_i = av; b_i = bv; start = 1'b1;
        push_exp(av, bv, cyc + 1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit poke);
        @(negedge clk);
        issue(av, bv);
        @(negedge clk);
        start = 1'b0;
        if (poke && !has_bad(av) && !has_bad(bv)) begin
            // start pulse with unrelated operands while RUN must be ignored
            start = 1'b1; a_i = W'($urandom); b_i = W'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_borrow", 64'(borrow), 64'd0);
        check("rst_invalid", 64'(invalid), 64'd0);
        rst = 1'b0;

        run_op(16'h4521, 16'h1234, 1'b0);
        run_op(16'h0123, 16'h0456, 1'b0);
        run_op(16'h1000, 16'h0001, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0);
        run_op(16'h12A4, 16'h0001, 1'b0);
        run_op(16'h4521, 16'h1234, 1'b1);

        // start held through RUN (with changing inputs) and into DONE
        @(negedge clk);
        issue(16'h7305, 16'h2468);
        repeat (DIGITS) begin
            @(negedge clk);
            a_i = W'($urandom); b_i = W'($urandom);
        end
        @(negedge clk);
        issue(16'h9999, 16'h9999);
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // reset after two digits of a run
        run_op(16'h0123, 16'h0456, 1'b0);
        @(negedge clk);
        issue(16'h8642, 16'h1357);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_diff", 64'(diff), 64'd0);
        check("mid_rst_borrow", 64'(borrow), 64'd0);
        check("mid_rst_invalid", 64'(invalid), 64'd0);
        q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (DIGITS + 3) @(negedge clk);
        run_op(16'h5000, 16'h0001, 1'b0);

        // randomized operands, occasionally with illegal nibbles
        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd();
            rb = ($urandom_range(0, 3) == 0) ? ra : rand_bcd();
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            run_op(ra, rb, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
